// File: rtl/word_tokenizer_if.sv
// Character-in / token-out bundle for the word tokenizer.
// The master side drives characters; the slave side returns completed-word tokens.
interface word_tokenizer_if #(
  parameter int unsigned LEN_W = 6
);
  logic [7:0]       in;
  logic             in_valid;
  logic             flush;
  logic             tok_valid;
  logic [1:0]       tok_kind;
  logic [LEN_W-1:0] tok_len;
  logic             in_word;

  modport master (
    output in, in_valid, flush,
    input  tok_valid, tok_kind, tok_len, in_word
  );

  modport slave (
    input  in, in_valid, flush,
    output tok_valid, tok_kind, tok_len, in_word
  );
endinterface

// File: rtl/word_tokenizer.sv
// Splits a space-delimited ASCII stream into words and classifies each word
// case-insensitively as BEGIN, END or OTHER, emitting one registered token per word.
module word_tokenizer #(
  parameter int unsigned LEN_W = 6
) (
  input logic             clk,
  input logic             reset,
  word_tokenizer_if.slave bus
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_B     = 4'd1;
  localparam logic [3:0] S_BE    = 4'd2;
  localparam logic [3:0] S_BEG   = 4'd3;
  localparam logic [3:0] S_BEGI  = 4'd4;
  localparam logic [3:0] S_BEGIN = 4'd5;
  localparam logic [3:0] S_E     = 4'd6;
  localparam logic [3:0] S_EN    = 4'd7;
  localparam logic [3:0] S_END   = 4'd8;
  localparam logic [3:0] S_OTH   = 4'd9;

  localparam logic [1:0] K_NONE  = 2'b00;
  localparam logic [1:0] K_BEGIN = 2'b01;
  localparam logic [1:0] K_END   = 2'b10;
  localparam logic [1:0] K_OTHER = 2'b11;

  localparam logic [LEN_W-1:0] CNT_MAX = '1;

  logic [3:0]       state, next_state, adv_state;
  logic [LEN_W-1:0] cnt, next_cnt, adv_cnt;
  logic             end_word, emit;
  logic [1:0]       kind;
  logic [7:0]       ch_up;
  logic             is_delim;

  // Only letters fold onto 'A'..'Z', so matching the folded byte is exact.
  assign ch_up    = bus.in & 8'hDF;
  assign is_delim = (bus.in == 8'h20);

  // A character accepted together with flush is consumed before the word terminates.
  always_comb begin
    adv_state = state;
    adv_cnt   = cnt;
    end_word  = bus.flush;
    if (bus.in_valid) begin
      if (is_delim) begin
        end_word = 1'b1;
      end else begin
        adv_cnt = (cnt == CNT_MAX) ? cnt : cnt + LEN_W'(1);
        case (state)
          S_IDLE:  adv_state = (ch_up == 8'h42) ? S_B :
                               (ch_up == 8'h45) ? S_E : S_OTH;
          S_B:     adv_state = (ch_up == 8'h45) ? S_BE    : S_OTH;
          S_BE:    adv_state = (ch_up == 8'h47) ? S_BEG   : S_OTH;
          S_BEG:   adv_state = (ch_up == 8'h49) ? S_BEGI  : S_OTH;
          S_BEGI:  adv_state = (ch_up == 8'h4E) ? S_BEGIN : S_OTH;
          S_E:     adv_state = (ch_up == 8'h4E) ? S_EN    : S_OTH;
          S_EN:    adv_state = (ch_up == 8'h44) ? S_END   : S_OTH;
          default: adv_state = S_OTH;
        endcase
      end
    end

    emit = end_word && (adv_state != S_IDLE);
    case (adv_state)
      S_BEGIN: kind = K_BEGIN;
      S_END:   kind = K_END;
      default: kind = K_OTHER;
    endcase

    next_state = end_word ? S_IDLE : adv_state;
    next_cnt   = end_word ? '0 : adv_cnt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Token registers load on the edge that accepts the terminator.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.tok_valid <= 1'b0;
      bus.tok_kind  <= K_NONE;
      bus.tok_len   <= '0;
      bus.in_word   <= 1'b0;
    end else begin
      bus.tok_valid <= emit;
      bus.tok_kind  <= emit ? kind : K_NONE;
      bus.tok_len   <= emit ? adv_cnt : '0;
      bus.in_word   <= (next_state != S_IDLE);
    end
  end

endmodule

// File: tb/tb_word_tokenizer.sv
// Bench for word_tokenizer: a word-level reference model checked every cycle,
// plus directed streams with hand-computed token expectations.
module tb_word_tokenizer;

  logic clk = 1'b0;
  logic reset;

  word_tokenizer_if #(.LEN_W(6)) b0 ();
  word_tokenizer_if #(.LEN_W(3)) b1 ();

  word_tokenizer #(.LEN_W(6)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  word_tokenizer #(.LEN_W(3)) dut1 (.clk(clk), .reset(reset), .bus(b1));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;

  // Token log of both instances for the directed expectations.
  int pk[$], pl[$], pc[$];
  int qk[$], ql[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Reference model: keeps the raw characters of the current word.
  logic [7:0] wbuf [0:63];
  int         wcnt = 0;
  logic       exp_valid = 1'b0, exp_inword = 1'b0;
  logic [1:0] exp_kind = 2'b00;
  int         exp_len0 = 0, exp_len1 = 0;

  function automatic logic [7:0] up(input logic [7:0] c);
    return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
  endfunction

  function automatic logic [1:0] kind_of();
    if (wcnt == 5 && up(wbuf[0]) == 8'h42 && up(wbuf[1]) == 8'h45 && up(wbuf[2]) == 8'h47 &&
        up(wbuf[3]) == 8'h49 && up(wbuf[4]) == 8'h4E)
      return 2'b01;
    if (wcnt == 3 && up(wbuf[0]) == 8'h45 && up(wbuf[1]) == 8'h4E && up(wbuf[2]) == 8'h44)
      return 2'b10;
    return 2'b11;
  endfunction

  always @(posedge clk) begin
    logic term;
    exp_valid = 1'b0;
    exp_kind  = 2'b00;
    exp_len0  = 0;
    exp_len1  = 0;
    if (!reset) begin
      wcnt       = 0;
      exp_inword = 1'b0;
    end else begin
      term = b0.flush;
      if (b0.in_valid) begin
        if (b0.in == 8'h20) term = 1'b1;
        else begin
          if (wcnt < 64) wbuf[wcnt] = b0.in;
          wcnt++;
        end
      end
      if (term && wcnt > 0) begin
        exp_valid = 1'b1;
        exp_kind  = kind_of();
        exp_len0  = (wcnt > 63) ? 63 : wcnt;
        exp_len1  = (wcnt > 7) ? 7 : wcnt;
      end
      if (term) wcnt = 0;
      exp_inword = (wcnt > 0);
    end
  end

  // Per-cycle compare, sampled after the edge has settled.
  always @(posedge clk) begin
    #1;
    cyc_n++;
    check("tok_valid",   32'(b0.tok_valid), 32'(exp_valid));
    check("tok_kind",    32'(b0.tok_kind),  32'(exp_kind));
    check("tok_len",     32'(b0.tok_len),   32'(exp_len0));
    check("in_word",     32'(b0.in_word),   32'(exp_inword));
    check("tok_valid_3", 32'(b1.tok_valid), 32'(exp_valid));
    check("tok_kind_3",  32'(b1.tok_kind),  32'(exp_kind));
    check("tok_len_3",   32'(b1.tok_len),   32'(exp_len1));
    check("in_word_3",   32'(b1.in_word),   32'(exp_inword));
    if (b0.tok_valid === 1'b1) begin
      pk.push_back(int'(b0.tok_kind));
      pl.push_back(int'(b0.tok_len));
      pc.push_back(cyc_n);
    end
    if (b1.tok_valid === 1'b1) begin
      qk.push_back(int'(b1.tok_kind));
      ql.push_back(int'(b1.tok_len));
    end
  end

  task automatic cyc(input logic [7:0] c, input logic v, input logic f, input logic r);
    b0.in = c; b0.in_valid = v; b0.flush = f;
    b1.in = c; b1.in_valid = v; b1.flush = f;
    reset = r;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) cyc(s[i], 1'b1, 1'b0, 1'b1);
  endtask

  task automatic clear_log();
    pk.delete(); pl.delete(); pc.delete(); qk.delete(); ql.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    b0.in = 8'h61; b0.in_valid = 1'b1; b0.flush = 1'b0;
    b1.in = 8'h61; b1.in_valid = 1'b1; b1.flush = 1'b0;
    @(negedge clk);
    cyc(8'h61, 1'b1, 1'b0, 1'b0);
    check("rst_tok_valid", 32'(b0.tok_valid), 32'd0);
    check("rst_tok_kind",  32'(b0.tok_kind),  32'd0);
    check("rst_tok_len",   32'(b0.tok_len),   32'd0);
    check("rst_in_word",   32'(b0.in_word),   32'd0);

    clear_log();
    send("a "); idle(2);
    check("t1_count", 32'(pk.size()), 32'd1);
    if (pk.size() == 1) begin
      check("t1_kind", 32'(pk[0]), 32'd3);
      check("t1_len",  32'(pl[0]), 32'd1);
    end

    clear_log();
    send(" BeGin End "); idle(2);
    check("t2_count", 32'(pk.size()), 32'd2);
    if (pk.size() == 2) begin
      check("t2_kind0", 32'(pk[0]), 32'd1);
      check("t2_len0",  32'(pl[0]), 32'd5);
      check("t2_kind1", 32'(pk[1]), 32'd2);
      check("t2_len1",  32'(pl[1]), 32'd3);
      check("t2_gap",   32'(pc[1] - pc[0]), 32'd4);
    end

    clear_log();
    send("endc end ends e "); idle(2);
    check("t3_count", 32'(pk.size()), 32'd4);
    if (pk.size() == 4) begin
      check("t3_kind0", 32'(pk[0]), 32'd3); check("t3_len0", 32'(pl[0]), 32'd4);
      check("t3_kind1", 32'(pk[1]), 32'd2); check("t3_len1", 32'(pl[1]), 32'd3);
      check("t3_kind2", 32'(pk[2]), 32'd3); check("t3_len2", 32'(pl[2]), 32'd4);
      check("t3_kind3", 32'(pk[3]), 32'd3); check("t3_len3", 32'(pl[3]), 32'd1);
    end

    clear_log();
    send("begin"); cyc(8'h00, 1'b0, 1'b1, 1'b1); idle(2);
    check("t4_count", 32'(pk.size()), 32'd1);
    if (pk.size() == 1) begin
      check("t4_kind", 32'(pk[0]), 32'd1);
      check("t4_len",  32'(pl[0]), 32'd5);
    end
    clear_log();
    cyc(8'h00, 1'b0, 1'b1, 1'b1); idle(2);
    check("t4_idle_flush", 32'(pk.size()), 32'd0);

    clear_log();
    send("xxxxxxxxxx "); idle(2);
    check("t5_count",  32'(pk.size()), 32'd1);
    check("t5_count3", 32'(qk.size()), 32'd1);
    if (pk.size() == 1) check("t5_len6", 32'(pl[0]), 32'd10);
    if (qk.size() == 1) begin
      check("t5_kind3", 32'(qk[0]), 32'd3);
      check("t5_len3",  32'(ql[0]), 32'd7);
    end

    clear_log();
    send("beg"); cyc(8'h00, 1'b0, 1'b0, 1'b0); send("in "); idle(2);
    check("t6_count", 32'(pk.size()), 32'd1);
    if (pk.size() == 1) begin
      check("t6_kind", 32'(pk[0]), 32'd3);
      check("t6_len",  32'(pl[0]), 32'd2);
    end

    clear_log();
    send("En"); cyc(8'h64, 1'b1, 1'b1, 1'b1); idle(2);
    check("t7_count", 32'(pk.size()), 32'd1);
    if (pk.size() == 1) begin
      check("t7_kind", 32'(pk[0]), 32'd2);
      check("t7_len",  32'(pl[0]), 32'd3);
    end

    clear_log();
    send("ab"); cyc(8'h20, 1'b1, 1'b1, 1'b1); send("  "); idle(2);
    check("t8_count", 32'(pk.size()), 32'd1);
    if (pk.size() == 1) check("t8_len", 32'(pl[0]), 32'd2);

    clear_log();
    send("b"); idle(3); send("e?"); idle(2); send(" ");
    idle(2);
    check("t9_count", 32'(pk.size()), 32'd1);
    if (pk.size() == 1) begin
      check("t9_kind", 32'(pk[0]), 32'd3);
      check("t9_len",  32'(pl[0]), 32'd3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
